// File: rtl/reg_bank_mp_if.sv
// reg_bank_mp_if: read/write/status bundle between decode/writeback and reg_bank_mp
interface reg_bank_mp_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
);
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic                     init_busy;
    modport master (output rd_addr, wr_en, wr_addr, wr_data, input rd_data, init_busy);
    modport slave  (input rd_addr, wr_en, wr_addr, wr_data, output rd_data, init_busy);
endinterface

// File: rtl/reg_bank_mp.sv
// reg_bank_mp: multi-read-port register file with XZR and post-reset clear; REGBANK_BYPASS_EN selects write-first reads
module reg_bank_mp #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
) (
    input logic         clk,
    input logic         rst,
    reg_bank_mp_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] XZR = '1;
    localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(DEPTH - 2);
`ifdef REGBANK_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    typedef enum logic {CLEAR, RUN} state_t;

    state_t                   state_q, state_d;
    logic [ADDR_W-1:0]        clr_idx_q, clr_idx_d;
    logic [DATA_W-1:0]        mem_q [DEPTH-1];
    logic [DATA_W-1:0]        mem_d [DEPTH-1];
    logic [NUM_RD*DATA_W-1:0] rd_data_q, rd_data_d;
    logic [ADDR_W-1:0]        ra;

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        mem_d     = mem_q;
        rd_data_d = '0;
        ra        = '0;
        if (state_q == CLEAR) begin
            mem_d[clr_idx_q] = '0;
            clr_idx_d        = clr_idx_q + ADDR_W'(1);
            state_d          = (clr_idx_q == CLR_LAST) ? RUN : CLEAR;
        end else begin
            for (int p = 0; p < NUM_RD; p++) begin
                ra = bus.rd_addr[p*ADDR_W +: ADDR_W];
                rd_data_d[p*DATA_W +: DATA_W] = (ra == XZR) ? '0 :
                    (BYPASS && bus.wr_en && bus.wr_addr == ra) ? bus.wr_data : mem_q[ra];
            end
            if (bus.wr_en && bus.wr_addr != XZR)
                mem_d[bus.wr_addr] = bus.wr_data;
        end
    end

    // storage is not reset; the clear sequence zeroes it before RUN
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= CLEAR;
            clr_idx_q <= '0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            rd_data_q <= rd_data_d;
            mem_q     <= mem_d;
        end
    end

    assign bus.rd_data   = rd_data_q;
    assign bus.init_busy = (state_q == CLEAR);
endmodule

// File: doc/reg_bank_mp.md
# reg_bank_mp

Parametrised multi-read-port general-purpose register file for the ARMv8 datapath. It is the successor to the two-port 64-bit bank. It adds:
- a configurable number of synchronous read ports;
- a hard-wired zero register (XZR) at the top index;
- a post-reset clear sequencer that zeroes every storage entry;
- optional write-to-read forwarding.

It sits between the decode stage, which supplies read addresses, and the writeback stage, which supplies write address and data.

## Interface
Parameters:
- DATA_W, 64, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries, index DEPTH-1 is XZR
- NUM_RD, 2, number of read ports, legal range 1..4

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- rd_addr  input  NUM_RD*ADDR_W  read addresses; port p occupies bits [p*ADDR_W +: ADDR_W]
- rd_data  output  NUM_RD*DATA_W  registered read data; port p occupies bits [p*DATA_W +: DATA_W]
- wr_en  input  1  write strobe
- wr_addr  input  ADDR_W  write address
- wr_data  input  DATA_W  write data
- init_busy  output  1  high while in reset or while the clear sequencer runs

## Operation
- Storage holds DEPTH-1 entries (indices 0..DEPTH-2). XZR is not stored.
- FSM has two states, CLEAR and RUN.
  - rst=1 at an edge: state <= CLEAR, clr_idx <= 0, all rd_data <= 0.
  - CLEAR: each cycle writes 0 to entry clr_idx, then clr_idx increments. When clr_idx == DEPTH-2 is cleared, state <= RUN.
  - RUN: normal operation. No exit except rst.
- rst asserted mid-clear restarts the sequence at index 0. rst asserted in RUN re-enters CLEAR; all contents are re-zeroed.
- Writes: in RUN, wr_en=1 and wr_addr != DEPTH-1 writes wr_data to the entry at the edge. A write to XZR is discarded. wr_en is ignored in CLEAR and during rst.
- Reads, per port p, evaluated independently at each edge in RUN:
  - rd_addr == DEPTH-1: rd_data_p <= 0.
  - otherwise rd_data_p <= entry[rd_addr], subject to the bypass rule in Configuration.
- In CLEAR, all rd_data are held at 0.
- Multiple ports reading the same address return identical data. Write-address/read-address collisions are resolved only as described in Configuration.
- init_busy = (state == CLEAR), decoded combinationally from state. It is therefore 1 during rst.

## Timing
- Reset values: rd_data = 0 on all ports, init_busy = 1, clr_idx = 0. Storage contents are undefined until the clear completes.
- Clear duration: after rst falls, init_busy stays 1 for exactly DEPTH-1 cycles (31 at ADDR_W=5). It falls at the edge that clears index DEPTH-2. The first write or read is accepted at the following edge.
- Read latency: 1 cycle. rd_addr sampled at edge N produces rd_data valid after edge N and held until edge N+1.
- Write latency: data written at edge N is visible to a read sampled at edge N+1 in both configurations.
- Throughput: one write and NUM_RD reads every cycle, no stalls in RUN.

## Configuration
- Macro: REGBANK_BYPASS_EN.
- Defined: write-first behaviour.
  - A read sampled at the same edge as a RUN write to the same non-XZR address returns wr_data.
  - Forwarding applies on every port independently.
- Undefined: read-first behaviour. Such a read returns the entry's value before the write, and the new value is visible from the next edge.
- XZR always reads 0 regardless of the macro, and forwarding never applies to address DEPTH-1.

## Test plan
- Reset/clear: pulse rst for 2 cycles, release. Required: init_busy=1 for exactly 31 cycles after release, then 0. Reading every address 0..30 returns 0.
- Write/read: write 0xDEADBEEF_CAFEF00D to x5, then read x5 on both ports next cycle. Required: both rd_data = 0xDEADBEEF_CAFEF00D one cycle after sampling.
- XZR: write 0x1234 to address 31, then read 31. Required: rd_data = 0 on every port; no stored entry changes.
- Collision: x7 = 0x11; at the same edge write 0x22 to x7 and read x7. Required: rd_data = 0x22 with REGBANK_BYPASS_EN, 0x11 without; the next read returns 0x22 in both.
- Writes during clear: assert wr_en to x3 with 0xFF while init_busy=1. Required: after the clear, x3 reads 0.
- Mid-clear reset: assert rst at clear cycle 10, write x30=0xAB after completion, then reset in RUN. Required: init_busy restarts its full 31-cycle count, and x30 reads 0 after the second clear.
